// File: rtl/utf8_stream_decoder.sv
// utf8_stream_decoder: UTF-8 byte stream to UTF-32/UTF-16 words with error markers and a show-ahead output FIFO
module utf8_stream_decoder #(
   parameter int DEPTH = 4,
   parameter int UTF16 = 0,
   parameter int CHK_RANGE = 1,
   parameter int REPLACE = 1
) (
   input  logic                     clk,
   input  logic                     rst_in,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   output logic [31:0]              out_data,
   output logic                     out_err,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              err_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   typedef enum logic [1:0] {IDLE, CONT, REDO} state_t;
   state_t state, state_n;
   logic [1:0] rem, rem_n, len, len_n;
   logic [20:0] acc, acc_n, nacc, min_v, pval, v;
   logic [21:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [9:0] hi10;
   logic run, beat, e, pair, full, pop, space, cont_byte, accept, push, perr;
   assign full = level == LW'(DEPTH);
   assign out_valid = level != '0;
   assign {e, v} = mem[rp];
   assign pair = (UTF16 != 0) && !e && v >= 21'h10000;
   assign pop = out_valid && out_ready && (!pair || beat);
   // a pop in the same cycle frees the slot the incoming word lands in
   assign space = !full || pop;
   assign cont_byte = in_data[7:6] == 2'b10;
   assign in_ready = run && space && !flush && !(state == CONT && in_valid && !cont_byte);
   assign accept = in_valid && in_ready;
   assign nacc = (acc << 6) | {15'd0, in_data[5:0]};
   assign min_v = len == 2'd1 ? 21'h80 : len == 2'd2 ? 21'h800 : 21'h10000;
   assign hi10 = 10'((v - 21'h10000) >> 10);
   assign out_err = out_valid && e;
   assign out_data = !out_valid ? 32'd0 :
                     e ? {16'd0, REPLACE != 0 ? 16'hFFFD : 16'h0000} :
                     pair ? {16'd0, beat ? {6'b110111, v[9:0]} : {6'b110110, hi10}} :
                     {11'd0, v};
   always_comb begin
      state_n = state;
      rem_n = rem;
      len_n = len;
      acc_n = acc;
      push = 1'b0;
      perr = 1'b0;
      pval = '0;
      if (state == CONT) begin
         if (flush && space) begin
            push = 1'b1;
            perr = 1'b1;
            state_n = IDLE;
         end else if (in_valid && !cont_byte && space) begin
            push = 1'b1;
            perr = 1'b1;
            state_n = REDO;
         end else if (accept) begin
            acc_n = nacc;
            rem_n = rem - 2'd1;
            if (rem == 2'd1) begin
               push = 1'b1;
               state_n = IDLE;
               perr = nacc < min_v ||
                      (CHK_RANGE != 0 && ((nacc >= 21'hD800 && nacc <= 21'hDFFF) || nacc > 21'h10FFFF)) ||
                      (UTF16 != 0 && nacc > 21'h10FFFF);
               pval = perr ? 21'd0 : nacc;
            end
         end
      end else begin
         // REDO reprocesses the byte left on the input as a fresh lead byte
         state_n = IDLE;
         if (accept) begin
            if (!in_data[7]) begin
               push = 1'b1;
               pval = {13'd0, in_data};
            end else if (in_data >= 8'hC2 && in_data <= 8'hDF) begin
               state_n = CONT;
               rem_n = 2'd1;
               len_n = 2'd1;
               acc_n = {16'd0, in_data[4:0]};
            end else if (in_data[7:4] == 4'hE) begin
               state_n = CONT;
               rem_n = 2'd2;
               len_n = 2'd2;
               acc_n = {17'd0, in_data[3:0]};
            end else if (in_data >= 8'hF0 && in_data <= (CHK_RANGE != 0 ? 8'hF4 : 8'hF7)) begin
               state_n = CONT;
               rem_n = 2'd3;
               len_n = 2'd3;
               acc_n = {18'd0, in_data[2:0]};
            end else begin
               push = 1'b1;
               perr = 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
         rem <= '0;
         len <= '0;
         acc <= '0;
         wp <= '0;
         rp <= '0;
         level <= '0;
         beat <= 1'b0;
         err_count <= '0;
         run <= 1'b0;
      end else begin
         run <= 1'b1;
         state <= state_n;
         rem <= rem_n;
         len <= len_n;
         acc <= acc_n;
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         level <= level + LW'(push) - LW'(pop);
         if (out_valid && out_ready) beat <= pair && !beat;
         if (push && perr && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= {perr, pval};
   end
endmodule

// File: tb/tb_utf8_stream_decoder.sv
// tb_utf8_stream_decoder: directed and randomized checks of three decoder configurations against a stream-level model
module tb_utf8_stream_decoder;
   logic clk = 1'b0;
   logic rst_in;
   logic [7:0] din [3];
   logic vin [3], fl [3], ordy [3];
   logic ir [3], ov [3], oe [3];
   logic [31:0] od [3];
   logic [2:0] lvl [3];
   logic [15:0] ec [3];
   int tests = 0, fails = 0;
   int unsigned toks [$];
   logic [32:0] expq [$];
   int exp_errs;
   int unsigned leads [6] = '{'hC0, 'hE0, 'hED, 'hF0, 'hF4, 'hF5};

   always #5 clk = ~clk;

   utf8_stream_decoder #(.DEPTH(4), .UTF16(0), .CHK_RANGE(1), .REPLACE(1)) d0 (
      .clk(clk), .rst_in(rst_in), .in_data(din[0]), .in_valid(vin[0]), .in_ready(ir[0]), .flush(fl[0]),
      .out_data(od[0]), .out_err(oe[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .level(lvl[0]), .err_count(ec[0]));
   utf8_stream_decoder #(.DEPTH(4), .UTF16(1), .CHK_RANGE(1), .REPLACE(1)) d1 (
      .clk(clk), .rst_in(rst_in), .in_data(din[1]), .in_valid(vin[1]), .in_ready(ir[1]), .flush(fl[1]),
      .out_data(od[1]), .out_err(oe[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .level(lvl[1]), .err_count(ec[1]));
   utf8_stream_decoder #(.DEPTH(4), .UTF16(0), .CHK_RANGE(0), .REPLACE(0)) d2 (
      .clk(clk), .rst_in(rst_in), .in_data(din[2]), .in_valid(vin[2]), .in_ready(ir[2]), .flush(fl[2]),
      .out_data(od[2]), .out_err(oe[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .level(lvl[2]), .err_count(ec[2]));

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int k, input logic [7:0] b);
      int n = 0;
      din[k] = b;
      vin[k] = 1'b1;
      @(negedge clk);
      while (!ir[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) check("send_ready", 32'(ir[k]), 1);
      @(posedge clk);
      #1;
      vin[k] = 1'b0;
   endtask

   task automatic expect_word(input int k, input logic [31:0] d, input logic e, input string tag);
      check({tag, "_valid"}, 32'(ov[k]), 1);
      check({tag, "_data"}, od[k], d);
      check({tag, "_err"}, 32'(oe[k]), 32'(e));
      ordy[k] = 1'b1;
      step();
      ordy[k] = 1'b0;
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      step();
      rst_in = 1'b1;
      step();
   endtask

   task automatic enc(input int unsigned cp);
      if (cp < 'h800) begin
         toks.push_back('hC0 | (cp >> 6));
         toks.push_back('h80 | (cp & 63));
      end else if (cp < 'h10000) begin
         toks.push_back('hE0 | (cp >> 12));
         toks.push_back('h80 | ((cp >> 6) & 63));
         toks.push_back('h80 | (cp & 63));
      end else begin
         toks.push_back('hF0 | (cp >> 18));
         toks.push_back('h80 | ((cp >> 12) & 63));
         toks.push_back('h80 | ((cp >> 6) & 63));
         toks.push_back('h80 | (cp & 63));
      end
   endtask

   // token 256 stands for a flush request
   task automatic gen(input int groups);
      int r;
      toks.delete();
      repeat (groups) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: toks.push_back($urandom_range(0, 'h7F));
            3: enc($urandom_range('h80, 'h7FF));
            4: enc($urandom_range('h800, 'hFFFF));
            5: enc($urandom_range('h10000, 'h10FFFF));
            6: toks.push_back($urandom_range('h80, 'hFF));
            7: begin
               toks.push_back($urandom_range('hC2, 'hF4));
               toks.push_back(256);
            end
            8: toks.push_back(256);
            default: begin
               toks.push_back(leads[$urandom_range(0, 5)]);
               repeat ($urandom_range(1, 3)) toks.push_back($urandom_range('h80, 'hBF));
            end
         endcase
      end
      toks.push_back(256);
   endtask

   task automatic emit(input int unsigned v, input bit e, input bit u16, input bit rep);
      if (e) begin
         expq.push_back({1'b1, rep ? 32'hFFFD : 32'h0});
         exp_errs++;
      end else if (u16 && v >= 'h10000) begin
         expq.push_back({1'b0, 32'('hD800 + ((v - 'h10000) >> 10))});
         expq.push_back({1'b0, 32'('hDC00 + (v & 'h3FF))});
      end else
         expq.push_back({1'b0, 32'(v)});
   endtask

   task automatic model(input bit u16, input bit chk, input bit rep);
      int i = 0;
      int n;
      int unsigned b, v, lim;
      expq.delete();
      exp_errs = 0;
      while (i < toks.size()) begin
         b = toks[i];
         i++;
         if (b == 256) continue;
         if (b < 'h80) begin
            emit(b, 0, u16, rep);
            continue;
         end
         n = 0;
         v = 0;
         lim = 0;
         if (b >= 'hC2 && b <= 'hDF) begin n = 1; v = b - 'hC0; lim = 'h80; end
         else if (b >= 'hE0 && b <= 'hEF) begin n = 2; v = b - 'hE0; lim = 'h800; end
         else if (b >= 'hF0 && b <= (chk ? 'hF4 : 'hF7)) begin n = 3; v = b - 'hF0; lim = 'h10000; end
         if (n == 0) begin
            emit(0, 1, u16, rep);
            continue;
         end
         while (n > 0 && i < toks.size() && toks[i] >= 'h80 && toks[i] <= 'hBF) begin
            v = v * 64 + (toks[i] - 'h80);
            i++;
            n--;
         end
         if (n > 0) emit(0, 1, u16, rep);
         else emit(v, v < lim || (chk && ((v >= 'hD800 && v <= 'hDFFF) || v > 'h10FFFF)) || (u16 && v > 'h10FFFF), u16, rep);
      end
   endtask

   task automatic run_random(input int k);
      int ptr = 0, cyc = 0;
      bit hold = 0;
      logic [31:0] hd;
      logic he;
      logic [32:0] w;
      while ((ptr < toks.size() || expq.size() > 0) && cyc < 20000) begin
         if (ptr < toks.size() && toks[ptr] == 256) begin
            fl[k] = 1'b1;
            vin[k] = 1'b0;
         end else begin
            fl[k] = 1'b0;
            vin[k] = ptr < toks.size() && $urandom_range(0, 4) != 0;
            din[k] = ptr < toks.size() ? 8'(toks[ptr]) : 8'h00;
         end
         ordy[k] = $urandom_range(0, 3) != 0;
         @(negedge clk);
         if (hold) begin
            check("hold_valid", 32'(ov[k]), 1);
            check("hold_data", od[k], hd);
            check("hold_err", 32'(oe[k]), 32'(he));
         end
         hold = ov[k] && !ordy[k];
         hd = od[k];
         he = oe[k];
         if (ov[k] && ordy[k]) begin
            if (expq.size() == 0) check("rand_extra_word", 32'(ov[k]), 0);
            else begin
               w = expq.pop_front();
               check("rand_data", od[k], w[31:0]);
               check("rand_err", 32'(oe[k]), 32'(w[32]));
            end
         end
         if (vin[k] && ir[k]) ptr++;
         if (fl[k] && lvl[k] != 3'd4) ptr++;
         @(posedge clk);
         #1;
         cyc++;
      end
      fl[k] = 1'b0;
      vin[k] = 1'b0;
      ordy[k] = 1'b0;
      check("rand_complete", ptr + expq.size(), toks.size());
      check("rand_level", 32'(lvl[k]), 0);
      check("rand_err_count", 32'(ec[k]), exp_errs);
   endtask

   initial begin
      rst_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         din[k] = 8'h00;
         vin[k] = 1'b0;
         fl[k] = 1'b0;
         ordy[k] = 1'b0;
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_level", 32'(lvl[k]), 0);
         check("rst_valid", 32'(ov[k]), 0);
         check("rst_data", od[k], 0);
         check("rst_err", 32'(oe[k]), 0);
         check("rst_ready", 32'(ir[k]), 0);
         check("rst_errcnt", 32'(ec[k]), 0);
      end
      step();
      step();
      rst_in = 1'b1;
      #1;
      check("ready_before_edge", 32'(ir[0]), 0);
      step();
      check("ready_after_edge", 32'(ir[0]), 1);

      send(0, 8'hE2);
      send(0, 8'h82);
      check("euro_not_yet", 32'(ov[0]), 0);
      send(0, 8'hAC);
      check("euro_level", 32'(lvl[0]), 1);
      expect_word(0, 32'h20AC, 1'b0, "euro");
      check("euro_drained", 32'(lvl[0]), 0);

      send(0, 8'hC0);
      send(0, 8'hAF);
      send(0, 8'hE0);
      send(0, 8'h80);
      send(0, 8'h80);
      check("ovl_level", 32'(lvl[0]), 3);
      expect_word(0, 32'hFFFD, 1'b1, "ovl_c0");
      expect_word(0, 32'hFFFD, 1'b1, "ovl_af");
      expect_word(0, 32'hFFFD, 1'b1, "ovl_e0");
      check("ovl_errcnt", 32'(ec[0]), 3);

      send(0, 8'hE2);
      send(0, 8'h82);
      din[0] = 8'h41;
      vin[0] = 1'b1;
      #1;
      check("trunc_ready_low", 32'(ir[0]), 0);
      step();
      check("redo_ready_high", 32'(ir[0]), 1);
      step();
      vin[0] = 1'b0;
      check("trunc_level", 32'(lvl[0]), 2);
      expect_word(0, 32'hFFFD, 1'b1, "trunc_err");
      expect_word(0, 32'h41, 1'b0, "trunc_redo");
      check("trunc_errcnt", 32'(ec[0]), 4);

      send(0, 8'hE2);
      send(0, 8'h82);
      fl[0] = 1'b1;
      #1;
      check("flush_ready_low", 32'(ir[0]), 0);
      step();
      fl[0] = 1'b0;
      check("flush_level", 32'(lvl[0]), 1);
      expect_word(0, 32'hFFFD, 1'b1, "flush_err");
      check("flush_errcnt", 32'(ec[0]), 5);
      fl[0] = 1'b1;
      step();
      fl[0] = 1'b0;
      check("flush_idle_level", 32'(lvl[0]), 0);
      check("flush_idle_errcnt", 32'(ec[0]), 5);

      send(0, 8'hED);
      send(0, 8'hA0);
      send(0, 8'h80);
      expect_word(0, 32'hFFFD, 1'b1, "surr_strict");
      check("surr_errcnt", 32'(ec[0]), 6);
      send(2, 8'hED);
      send(2, 8'hA0);
      send(2, 8'h80);
      expect_word(2, 32'hD800, 1'b0, "surr_loose");
      send(2, 8'hC0);
      expect_word(2, 32'h0, 1'b1, "zero_replace");
      send(2, 8'hF5);
      send(2, 8'h80);
      send(2, 8'h80);
      send(2, 8'h80);
      expect_word(2, 32'h140000, 1'b0, "f5_loose");
      check("loose_errcnt", 32'(ec[2]), 1);

      send(1, 8'hF0);
      send(1, 8'h9F);
      send(1, 8'h98);
      send(1, 8'h80);
      check("pair_level", 32'(lvl[1]), 1);
      expect_word(1, 32'hD83D, 1'b0, "pair_hi");
      check("pair_level_mid", 32'(lvl[1]), 1);
      expect_word(1, 32'hDE00, 1'b0, "pair_lo");
      check("pair_level_end", 32'(lvl[1]), 0);

      for (int i = 0; i < 4; i++) send(0, 8'(8'h30 + i));
      check("full_level", 32'(lvl[0]), 4);
      din[0] = 8'h34;
      vin[0] = 1'b1;
      #1;
      check("full_ready_low", 32'(ir[0]), 0);
      ordy[0] = 1'b1;
      #1;
      check("full_pop_ready", 32'(ir[0]), 1);
      check("full_pop_data", od[0], 32'h30);
      step();
      vin[0] = 1'b0;
      ordy[0] = 1'b0;
      check("full_pushpop_level", 32'(lvl[0]), 4);
      for (int i = 1; i < 5; i++) expect_word(0, 32'(32'h30 + i), 1'b0, "full_drain");

      send(0, 8'hE2);
      send(1, 8'hF0);
      send(1, 8'h9F);
      send(1, 8'h98);
      send(1, 8'h80);
      expect_word(1, 32'hD83D, 1'b0, "mid_pair_hi");
      rst_in = 1'b0;
      #1;
      check("midrst_level1", 32'(lvl[1]), 0);
      check("midrst_valid1", 32'(ov[1]), 0);
      check("midrst_errcnt0", 32'(ec[0]), 0);
      check("midrst_ready0", 32'(ir[0]), 0);
      step();
      rst_in = 1'b1;
      step();
      send(0, 8'h41);
      expect_word(0, 32'h41, 1'b0, "post_rst_ascii");
      check("post_rst_errcnt", 32'(ec[0]), 0);
      send(1, 8'hF0);
      send(1, 8'h9F);
      send(1, 8'h98);
      send(1, 8'h80);
      expect_word(1, 32'hD83D, 1'b0, "post_rst_hi");
      expect_word(1, 32'hDE00, 1'b0, "post_rst_lo");

      for (int k = 0; k < 3; k++) begin
         do_reset();
         gen(150);
         model(k == 1, k != 2, k != 2);
         run_random(k);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
